// File: rtl/mips_inst_encoder.sv
// mips_inst_encoder: packs mnemonic/field tuples into MIPS words and streams them into the instruction memory.
module mips_inst_encoder #(
  parameter int          IM_DEPTH  = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  localparam int         CW        = $clog2(IM_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    in_mnem,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_shamt,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  input  logic          in_last,
  output logic          im_we,
  output logic [31:0]   im_addr,
  output logic [31:0]   im_wdata,
  output logic [CW-1:0] count,
  output logic          done,
  output logic          full,
  output logic          err,
  output logic [5:0]    err_mnem
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE, ERROR} state_t;
  state_t        r_state, w_nstate;
  logic [31:0]   r_wdata, r_addr, w_word;
  logic [CW-1:0] r_count, w_cnt_nx;
  logic          r_last, r_done, r_full, r_err;
  logic [5:0]    r_err_mnem, w_op, w_funct;
  logic [4:0]    w_rs, w_rt, w_rd, w_sh;
  logic          w_legal, w_rtype, w_cshift, w_jr, w_jalr, w_iform, w_jump, w_fire;
  always_comb begin
    w_op = 6'd0;
    w_funct = 6'd0;
    case (in_mnem)
      6'd0:  w_funct = 6'h21;
      6'd1:  w_funct = 6'h23;
      6'd2:  w_funct = 6'h2A;
      6'd3:  w_funct = 6'h2B;
      6'd4:  w_funct = 6'h00;
      6'd5:  w_funct = 6'h03;
      6'd6:  w_funct = 6'h02;
      6'd7:  w_funct = 6'h24;
      6'd8:  w_funct = 6'h27;
      6'd9:  w_funct = 6'h25;
      6'd10: w_funct = 6'h26;
      6'd11: w_funct = 6'h04;
      6'd12: w_funct = 6'h07;
      6'd13: w_funct = 6'h06;
      6'd14: w_funct = 6'h09;
      6'd15: w_funct = 6'h08;
      6'd16, 6'd17: w_op = 6'h01;
      6'd18: w_op = 6'h2B;
      6'd19: w_op = 6'h28;
      6'd20: w_op = 6'h23;
      6'd21: w_op = 6'h20;
      6'd22: w_op = 6'h24;
      6'd23: w_op = 6'h0A;
      6'd24: w_op = 6'h0B;
      6'd25: w_op = 6'h0C;
      6'd26: w_op = 6'h0D;
      6'd27: w_op = 6'h0E;
      6'd28: w_op = 6'h0F;
      6'd29: w_op = 6'h09;
      6'd30: w_op = 6'h08;
      6'd31: w_op = 6'h04;
      6'd32: w_op = 6'h07;
      6'd33: w_op = 6'h06;
      6'd34: w_op = 6'h05;
      6'd35: w_op = 6'h02;
      6'd36: w_op = 6'h03;
      default: ;
    endcase
  end
  // Field masking: unused fields are zeroed so garbage inputs never leak into the word.
  assign w_legal  = in_mnem <= 6'd37;
  assign w_rtype  = in_mnem < 6'd16;
  assign w_cshift = in_mnem inside {6'd4, 6'd5, 6'd6};
  assign w_jalr   = in_mnem == 6'd14;
  assign w_jr     = in_mnem == 6'd15;
  assign w_iform  = in_mnem >= 6'd16 && in_mnem <= 6'd34;
  assign w_jump   = in_mnem == 6'd35 || in_mnem == 6'd36;
  assign w_rs     = (w_cshift || in_mnem == 6'd28) ? 5'd0 : in_rs;
  assign w_rt     = (w_jr || w_jalr || in_mnem == 6'd32 || in_mnem == 6'd33 || in_mnem == 6'd17) ? 5'd0 :
                    in_mnem == 6'd16 ? 5'd1 : in_rt;
  assign w_rd     = w_jr ? 5'd0 : in_rd;
  assign w_sh     = w_cshift ? in_shamt : 5'd0;
  assign w_word   = w_rtype ? {6'd0, w_rs, w_rt, w_rd, w_sh, w_funct} :
                    w_iform ? {w_op, w_rs, w_rt, in_imm} :
                    w_jump  ? {w_op, in_target} : 32'd0;
  assign w_fire   = in_valid && r_state == IDLE;
  assign w_cnt_nx = r_count + 1'b1;
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_nstate = w_legal ? WRITE : ERROR;
      WRITE:   w_nstate = (r_last || w_cnt_nx == CW'(IM_DEPTH)) ? DONE : IDLE;
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_wdata    <= 32'd0;
      r_addr     <= BASE_ADDR;
      r_last     <= 1'b0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_full     <= 1'b0;
      r_err      <= 1'b0;
      r_err_mnem <= 6'd0;
    end else begin
      r_state <= w_nstate;
      if (w_fire && w_legal) begin
        r_wdata <= w_word;
        r_addr  <= BASE_ADDR + (32'(r_count) << 2);
        r_last  <= in_last;
      end
      if (w_fire && !w_legal) begin
        r_err      <= 1'b1;
        r_err_mnem <= in_mnem;
      end
      if (r_state == WRITE) begin
        r_count <= w_cnt_nx;
        r_done  <= r_last;
        r_full  <= w_cnt_nx == CW'(IM_DEPTH);
      end
    end
  end
  assign in_ready = r_state == IDLE;
  assign im_we    = r_state == WRITE;
  assign im_addr  = r_addr;
  assign im_wdata = r_wdata;
  assign count    = r_count;
  assign done     = r_done;
  assign full     = r_full;
  assign err      = r_err;
  assign err_mnem = r_err_mnem;
endmodule

// File: tb/tb_mips_inst_encoder.sv
// tb_mips_inst_encoder: directed and random instruction streams checked against a table-driven encoding model.
module tb_mips_inst_encoder;
  localparam int DEPTH = 4;
  logic        clk = 1'b0, reset = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0;
  logic [5:0]  in_mnem = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        in_ready, im_we, done, full, err;
  logic [31:0] im_addr, im_wdata;
  logic [2:0]  count;
  logic [5:0]  err_mnem;
  int checks = 0, errors = 0;
  int mcount;
  bit mdone, mfull, merr;
  logic [31:0] last_word, last_addr;
  int rf[16]  = '{'h21, 'h23, 'h2A, 'h2B, 'h00, 'h03, 'h02, 'h24, 'h27, 'h25, 'h26, 'h04, 'h07, 'h06, 'h09, 'h08};
  int iop[19] = '{'h2B, 'h28, 'h23, 'h20, 'h24, 'h0A, 'h0B, 'h0C, 'h0D, 'h0E, 'h0F, 'h09, 'h08, 'h04, 'h07, 'h06, 'h05, 'h02, 'h03};

  mips_inst_encoder #(.IM_DEPTH(DEPTH), .BASE_ADDR(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .count(count), .done(done), .full(full), .err(err), .err_mnem(err_mnem));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(int m, int rs, int rt, int rd, int sh, int imm, int tgt);
    longint w;
    if (m < 16) begin
      if (m == 4 || m == 5 || m == 6) rs = 0; else sh = 0;
      if (m == 15) begin rt = 0; rd = 0; end
      if (m == 14) rt = 0;
      w = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + sh * 64'd64 + rf[m];
    end else if (m <= 17) w = 64'd67108864 + rs * 64'd2097152 + (m == 16 ? 64'd65536 : 64'd0) + imm;
    else if (m <= 34) begin
      if (m == 28) rs = 0;
      if (m == 32 || m == 33) rt = 0;
      w = iop[m-18] * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
    end else if (m <= 36) w = iop[m-18] * 64'd67108864 + tgt;
    else w = 0;
    return w[31:0];
  endfunction

  task automatic rst_dut();
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_we", im_we, 0);
    chk("rst_addr", im_addr, 32'h3000);
    chk("rst_wdata", im_wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_flags", {done, full, err}, 0);
    chk("rst_err_mnem", err_mnem, 0);
    @(negedge clk);
    reset = 1'b1;
    mcount = 0; mdone = 0; mfull = 0; merr = 0;
    last_word = 0; last_addr = 32'h3000;
  endtask

  // Entered and left at a negedge so consecutive calls stream back-to-back.
  task automatic send(int m, int rs, int rt, int rd, int sh, int imm, int tgt, bit last);
    bit term = mdone || mfull || merr;
    in_mnem = 6'(m); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_shamt = 5'(sh);
    in_imm = 16'(imm); in_target = 26'(tgt); in_last = last; in_valid = 1'b1;
    chk("ready", in_ready, !term);
    if (term) begin
      @(negedge clk);
      chk("term_we", im_we, 0);
      chk("term_ready", in_ready, 0);
      in_valid = 1'b0;
      return;
    end
    if (m > 37) begin
      @(negedge clk);
      in_valid = 1'b0;
      merr = 1;
      chk("ill_err", err, 1);
      chk("ill_mnem", err_mnem, m);
      chk("ill_we", im_we, 0);
      chk("ill_ready", in_ready, 0);
      chk("ill_count", count, mcount);
      return;
    end
    last_word = enc(m, rs, rt, rd, sh, imm, tgt);
    last_addr = 32'h3000 + 4 * mcount;
    @(negedge clk);
    chk("wr_we", im_we, 1);
    chk("wr_ready", in_ready, 0);
    chk("wr_addr", im_addr, last_addr);
    chk("wr_wdata", im_wdata, last_word);
    chk("wr_count", count, mcount);
    @(negedge clk);
    in_valid = 1'b0;
    mcount++;
    if (last) mdone = 1;
    if (mcount == DEPTH) mfull = 1;
    chk("post_we", im_we, 0);
    chk("post_count", count, mcount);
    chk("post_flags", {done, full, err}, {mdone, mfull, 1'b0});
    chk("post_ready", in_ready, !(mdone || mfull));
    chk("post_addr", im_addr, last_addr);
    chk("post_wdata", im_wdata, last_word);
  endtask

  initial begin
    rst_dut();
    send(0, 1, 2, 3, 0, 0, 0, 0);
    chk("addu_word", last_word, 32'h0022_1821);
    send(26, 0, 8, 31, 31, 'h1234, 0, 0);
    chk("ori_word", last_word, 32'h3408_1234);
    send(4, 31, 1, 2, 4, 0, 0, 0);
    chk("sll_word", last_word, 32'h0001_1100);
    send(16, 5, 0, 0, 0, 'hFFFF, 0, 1);
    chk("bgez_word", last_word, 32'h04A1_FFFF);
    chk("bgez_addr", last_addr, 32'h300C);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("done_hold_ready", in_ready, 0);
      chk("done_hold_we", im_we, 0);
    end
    rst_dut();
    send(2, 1, 2, 3, 0, 0, 0, 0);
    send(40, 1, 2, 3, 0, 0, 0, 0);
    send(0, 1, 2, 3, 0, 0, 0, 0);
    rst_dut();
    for (int i = 0; i < DEPTH + 1; i++) send(37, 9, 9, 9, 9, 9, 9, 0);
    chk("cap_full", {full, done}, 2'b10);
    rst_dut();
    send(1, 3, 4, 5, 0, 0, 0, 0);
    in_mnem = 6'd0; in_valid = 1'b1;
    @(negedge clk);
    chk("mid_we_before", im_we, 1);
    reset = 1'b0;
    #1;
    chk("mid_we", im_we, 0);
    chk("mid_count", count, 0);
    chk("mid_ready", in_ready, 1);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mcount = 0; mdone = 0; mfull = 0; merr = 0;
    send(29, 7, 6, 0, 0, 'h8001, 0, 0);
    chk("mid_next_addr", last_addr, 32'h3000);
    for (int p = 0; p < 40; p++) begin
      int len;
      rst_dut();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        int m = ($urandom_range(0, 99) < 8) ? $urandom_range(38, 63) : $urandom_range(0, 37);
        send(m, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 32'h3FF_FFFF),
             (i == len - 1) && $urandom_range(0, 1) == 1);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_inst_encoder.md
# mips_inst_encoder

Sequential MIPS instruction encoder feeding the instruction memory: the write-side counterpart of the control decoder. It accepts one instruction per valid/ready handshake as a mnemonic ID plus register/immediate fields, and packs it into a 32-bit MIPS word. It writes the words to consecutive instruction-memory addresses and reports completion, capacity exhaustion or an illegal mnemonic. It sits between the test/boot loader and the IM write port.

## Interface
- IM_DEPTH, 1024: IM capacity in words.
- BASE_ADDR, 32'h0000_3000: byte address of the first written word.

- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept.
- in_mnem  in  6  mnemonic ID (see Operation).
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register fields / shift amount.
- in_imm  in  16  immediate / branch offset.
- in_target  in  26  jump target field.
- in_last  in  1  final instruction of the program.
- im_we  out  1  IM write strobe.
- im_addr  out  32  byte address, BASE_ADDR + 4*count.
- im_wdata  out  32  encoded word.
- count  out  $clog2(IM_DEPTH)+1  words written.
- done, full, err  out  1 each  sticky status.
- err_mnem  out  6  offending ID on err.

## Operation
- Mnemonic IDs:
  - 0-15 R-type (op 0), funct: addu 21, subu 23, slt 2A, sltu 2B, sll 00, sra 03, srl 02, and 24, nor 27, or 25, xor 26, sllv 04, srav 07, srlv 06, jalr 09, jr 08.
  - 16 bgez and 17 bltz: op 01, rt 1 and 0 respectively.
  - 18-31 I-type opcodes: sw 2B, sb 28, lw 23, lb 20, lbu 24, slti 0A, sltiu 0B, andi 0C, ori 0D, xori 0E, lui 0F, addiu 09, addi 08, beq 04.
  - 32-37: bgtz 07, blez 06, bne 05, j 02, jal 03, nop (word 0).
  - 38-63 illegal.
- Field packing: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0]; imm[15:0]; target[25:0].
- Unused fields are forced to 0 regardless of input:
  - shamt in all non-constant-shift instructions.
  - rs in sll/sra/srl/lui.
  - rt and rd in jr.
  - rt in jalr, bgtz, blez.
  - shamt and rd in all I-types.
- Variable shifts take the shift register in rs.
- FSM states IDLE, WRITE, DONE, ERROR.
  - IDLE: in_ready=1. On in_valid&in_ready with a legal ID: the encoded word, im_addr and in_last are registered; go to WRITE.
  - IDLE, illegal ID: err=1, err_mnem=in_mnem; go to ERROR; nothing is written.
  - WRITE: im_we=1, in_ready=0. At the closing edge count increments. Next state is DONE if last is held, DONE with full=1 if count reaches IM_DEPTH, otherwise IDLE.
  - DONE/ERROR: in_ready=0, im_we=0. Terminal until reset.
- im_wdata/im_addr hold their last values outside WRITE.

## Timing
- Reset (async assert, sync release): state IDLE, in_ready=1 from the first cycle, im_we=0, im_addr=BASE_ADDR, im_wdata=0, count=0, done=full=err=0, err_mnem=0.
- Accept at edge N; im_we high during cycle N+1; write commits at edge N+1; count updates at edge N+1.
- in_ready rises at N+1 → next accept at edge N+2. Throughput is 1 word per 2 cycles.
- in_ready is not dependent on in_valid. Fields are sampled only on handshake; no combinational path exists from inputs to outputs.
- done or full asserts in the cycle after the final write edge.
- in_last together with the IM_DEPTH-th word sets both done and full.
- Reset asserted mid-WRITE: the pending write is dropped, im_we falls immediately, count=0.

## Test plan
- addu: mnem 0, rs 1, rt 2, rd 3 -> one im_we pulse, im_addr 0x3000, im_wdata 0x00221821, count 1.
- ori: mnem 26, rs 0, rt 8, imm 0x1234, garbage rd/shamt=31 -> 0x34081234 at 0x3004.
- sll: mnem 4, rs 31 (ignored), rt 1, rd 2, shamt 4 -> 0x00011100. Then bgez: mnem 16, rs 5, imm 0xFFFF, in_last -> 0x04A1FFFF at 0x300C; done=1 next cycle; in_ready stays 0 with in_valid held high.
- Illegal ID: mnem 40 -> err=1, err_mnem=40; no im_we pulse; in_ready=0 thereafter.
- Capacity: IM_DEPTH=4, stream 4 non-last nops back-to-back -> writes at 0x3000-0x300C, count 4, full=1, done=0, in_ready=0.
- Mid-write reset: assert reset during WRITE -> im_we=0 immediately, count 0, in_ready=1 after release; next word lands at 0x3000.
